ucsbece154b_prefetcher: RTL and testbench

Sequential instruction prefetcher that acts as the writer for the fetch FIFO. It issues in-order memory read requests at consecutive word addresses and pushes returned data into the FIFO. It tracks FIFO occupancy plus in-flight requests so that it never pushes into a full FIFO. On a redirect it flushes the FIFO, discards stale responses and resumes fetching from the new PC.

---
 rtl/ucsbece154b_prefetch_pkg.sv | 15 +
 rtl/ucsbece154b_prefetcher_if.sv | 36 +++
 rtl/ucsbece154b_prefetcher.sv | 151 +++++++++++++++
 tb/tb_ucsbece154b_prefetcher.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_prefetch_pkg.sv
// Shared types and helpers for the sequential instruction prefetcher.
package ucsbece154b_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } prefetch_state_e;

    // Bits needed to hold a credit count in the range 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ucsbece154b_prefetcher_if.sv
// Request/response/FIFO-write bundle between the prefetcher and its environment.
// master: the prefetcher side. slave: memory, FIFO and fetch-control side.
interface ucsbece154b_prefetcher_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);

    logic                  en_i;
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  req_valid_o;
    logic [ADDR_WIDTH-1:0] req_addr_o;
    logic                  req_ready_i;
    logic                  resp_valid_i;
    logic [DATA_WIDTH-1:0] resp_data_i;
    logic                  push_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  pop_i;
    logic                  flush_o;
    logic                  busy_o;
    logic [31:0]           stall_cycles_o;
    logic [31:0]           drop_count_o;

    modport master (
        input  en_i, redirect_i, redirect_pc_i, req_ready_i, resp_valid_i, resp_data_i, pop_i,
        output req_valid_o, req_addr_o, push_o, data_o, flush_o, busy_o, stall_cycles_o,
               drop_count_o
    );

    modport slave (
        output en_i, redirect_i, redirect_pc_i, req_ready_i, resp_valid_i, resp_data_i, pop_i,
        input  req_valid_o, req_addr_o, push_o, data_o, flush_o, busy_o, stall_cycles_o,
               drop_count_o
    );

endinterface

// File: rtl/ucsbece154b_prefetcher.sv
// Sequential instruction prefetcher acting as the write side of the fetch FIFO.
// Issues in-order word reads, pushes responses into the FIFO and never overfills it by
// counting FIFO entries plus live in-flight requests. A redirect flushes the FIFO and
// drops responses to requests issued before it.
// Optional perf counters: define UCSBECE154B_PREFETCH_PERF_EN.
module ucsbece154b_prefetcher
    import ucsbece154b_prefetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           NR_ENTRIES      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input logic                      clk,
    input logic                      rst,
    ucsbece154b_prefetcher_if.master bus
);

    localparam int unsigned ResW = cnt_width(NR_ENTRIES);
    localparam int unsigned OutW = cnt_width(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] Stride = ADDR_WIDTH'(DATA_WIDTH / 8);

    prefetch_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [OutW-1:0]       out_q, out_d;
    logic [OutW-1:0]       drop_q, drop_d;
    logic [ResW-1:0]       res_q, res_d;

    logic in_run;
    logic credit_ok;
    logic req_valid;
    logic accept;
    logic resp;
    logic push;
    logic pop_eff;

    // Handshake decode; nothing here depends combinationally on req_ready_i except accept,
    // which only feeds state.
    always_comb begin
        in_run    = (state_q == RUN);
        credit_ok = (res_q < ResW'(NR_ENTRIES)) && (out_q < OutW'(MAX_OUTSTANDING));
        req_valid = in_run && bus.en_i && !bus.redirect_i && credit_ok;
        accept    = req_valid && bus.req_ready_i;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp      = bus.resp_valid_i && (out_q != '0);
        push      = resp && in_run && !bus.redirect_i;
        // res_q==0 means the FIFO is empty, so a pop there cannot be genuine.
        pop_eff   = bus.pop_i && !bus.redirect_i && (res_q != '0);
    end

    // Next-state for the FSM and credit counters, all deltas applied together.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q + OutW'(accept) - OutW'(resp);
        res_d   = res_q + ResW'(accept) - ResW'(pop_eff);
        drop_d  = drop_q;

        if (bus.redirect_i) begin
            pc_d   = bus.redirect_pc_i;
            res_d  = '0;
            // Everything still in flight after this cycle is stale.
            drop_d = out_d;
        end else begin
            if (accept) begin
                pc_d = pc_q + Stride;
            end
            if (resp && (state_q == DRAIN)) begin
                drop_d = drop_q - OutW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.redirect_i) begin
                    if (out_d != '0) begin
                        state_d = DRAIN;
                    end
                end else if (!bus.en_i && (out_q == '0)) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Covers both the last stale response and a re-redirect with nothing left.
                state_d = (drop_d == '0) ? RUN : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            res_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            res_q   <= res_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.req_valid_o = req_valid;
    assign bus.req_addr_o  = pc_q;
    assign bus.push_o      = push;
    assign bus.data_o      = bus.resp_data_i;
    assign bus.flush_o     = bus.redirect_i;
    assign bus.busy_o      = (out_q != '0) || (state_q != IDLE);

`ifdef UCSBECE154B_PREFETCH_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] dropc_q;

    // Saturating perf counters: credit-blocked fetch cycles and dropped responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            dropc_q <= '0;
        end else begin
            if (in_run && bus.en_i && !bus.redirect_i && !credit_ok && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (resp && !push && (dropc_q != '1)) begin
                dropc_q <= dropc_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles_o = stall_q;
    assign bus.drop_count_o   = dropc_q;
`else
    assign bus.stall_cycles_o = '0;
    assign bus.drop_count_o   = '0;
`endif

    resp_without_req_a: assert property (
        @(posedge clk) disable iff (rst) !(bus.resp_valid_i && (out_q == '0))
    );

endmodule

// File: tb/tb_ucsbece154b_prefetcher.sv
// Self-checking bench for ucsbece154b_prefetcher: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_ucsbece154b_prefetcher;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NE = 4;
    localparam int unsigned MO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ucsbece154b_prefetcher_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ucsbece154b_prefetcher #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .NR_ENTRIES      (NE),
        .MAX_OUTSTANDING (MO),
        .RESET_PC        ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: every accepted request lives in q until its response returns.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        q[$];
    int          fifo_cnt;
    logic [31:0] m_pc;
    bit          running;
    longint      m_stall;
    longint      m_drop;
    int          cyc;
    int          min_delay;
    int          max_delay;

    int checks = 0;
    int passes = 0;

    bit          s_req_valid;
    logic [31:0] s_req_addr;
    bit          s_push;
    bit          s_flush;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive_idle();
        bus.en_i          = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.req_ready_i   = 1'b0;
        bus.resp_valid_i  = 1'b0;
        bus.resp_data_i   = '0;
        bus.pop_i         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        check("rst_req_valid", bus.req_valid_o, 0);
        check("rst_push", bus.push_o, 0);
        check("rst_flush", bus.flush_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_stall", bus.stall_cycles_o, 0);
        check("rst_drop", bus.drop_count_o, 0);
        q.delete();
        fifo_cnt = 0;
        m_pc     = 32'h0;
        running  = 1'b0;
        m_stall  = 0;
        m_drop   = 0;
        rst      = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit en, input bit redir, input logic [31:0] rpc, input bit ready,
                        input bit resp_en, input bit pop_req);
        bit          drain, resp, pop, exp_rv, exp_push, accept;
        int          live, res, qsz;
        logic [31:0] rdata;
        @(negedge clk);
        qsz   = q.size();
        drain = (qsz > 0) && q[0].stale;
        resp  = resp_en && (qsz > 0) && (cyc >= q[0].due);
        pop   = pop_req && (fifo_cnt > 0);
        rdata = $urandom;
        bus.en_i          = en;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.req_ready_i   = ready;
        bus.resp_valid_i  = resp;
        bus.resp_data_i   = rdata;
        bus.pop_i         = pop;
        #1;
        live = 0;
        foreach (q[i]) if (!q[i].stale) live++;
        res      = fifo_cnt + live;
        exp_rv   = running && !drain && en && !redir && (res < NE) && (qsz < MO);
        exp_push = resp && running && !drain && !redir;

        check("req_valid", bus.req_valid_o, exp_rv);
        if (exp_rv) check("req_addr", bus.req_addr_o, m_pc);
        check("push", bus.push_o, exp_push);
        if (exp_push) check("data", bus.data_o, rdata);
        check("flush", bus.flush_o, redir);
        check("busy", bus.busy_o, running || (qsz > 0));
`ifdef UCSBECE154B_PREFETCH_PERF_EN
        check("stall_cycles", bus.stall_cycles_o, m_stall);
        check("drop_count", bus.drop_count_o, m_drop);
`else
        check("stall_cycles", bus.stall_cycles_o, 0);
        check("drop_count", bus.drop_count_o, 0);
`endif
        s_req_valid = bus.req_valid_o;
        s_req_addr  = bus.req_addr_o;
        s_push      = bus.push_o;
        s_flush     = bus.flush_o;

        accept = exp_rv && ready;
        if (running && !drain && en && !redir && !((res < NE) && (qsz < MO))) m_stall++;
        if (resp) begin
            void'(q.pop_front());
            if (exp_push) fifo_cnt++;
            else m_drop++;
        end
        if (pop && !redir) fifo_cnt--;
        if (redir) begin
            fifo_cnt = 0;
            foreach (q[i]) q[i].stale = 1'b1;
            m_pc = rpc;
        end
        if (accept) begin
            q.push_back('{addr: m_pc, due: cyc + $urandom_range(max_delay, min_delay),
                          stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (!running) running = en;
        else if (!drain && !redir && !en && (qsz == 0)) running = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [31:0] addrs[$];
        logic [31:0] first_addr;
        int          n_push, n_acc;
        bit          found;
        bit          en_r;

        cyc       = 0;
        min_delay = 1;
        max_delay = 1;
        drive_idle();
        do_reset();

        // Fill: 4 requests at consecutive words, then credits block further issue.
        n_push = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 1, 1, 0);
            if (s_req_valid) addrs.push_back(s_req_addr);
            if (s_push) n_push++;
        end
        check("fill_count", addrs.size(), 4);
        check("fill_a0", addrs[0], 32'h0);
        check("fill_a1", addrs[1], 32'h4);
        check("fill_a2", addrs[2], 32'h8);
        check("fill_a3", addrs[3], 32'hC);
        check("fill_pushes", n_push, 4);
        check("fill_blocked", s_req_valid, 0);

        // One pop frees exactly one credit.
        step(1, 0, 0, 1, 1, 1);
        check("pop_same_cycle_no_req", s_req_valid, 0);
        step(1, 0, 0, 1, 1, 0);
        check("pop_next_req", s_req_valid, 1);
        check("pop_next_addr", s_req_addr, 32'h10);
        step(1, 0, 0, 1, 1, 0);
        check("pop_only_one", s_req_valid, 0);

        // Outstanding limit with slow memory, then redirect with 2 in flight.
        min_delay = 5;
        max_delay = 5;
        step(1, 1, 32'h40, 1, 1, 0);
        check("redir0_flush", s_flush, 1);
        step(1, 0, 0, 1, 1, 0);
        check("slow_a0", s_req_addr, 32'h40);
        step(1, 0, 0, 1, 1, 0);
        check("slow_a1", s_req_addr, 32'h44);
        step(1, 0, 0, 1, 1, 0);
        check("slow_limit", s_req_valid, 0);
        step(1, 1, 32'h100, 1, 1, 0);
        check("redir1_flush", s_flush, 1);
        check("redir1_push", s_push, 0);
        n_push = 0;
        found  = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, 1, 1, 0);
            if (s_push) n_push++;
            if (s_req_valid) begin
                found      = 1;
                first_addr = s_req_addr;
            end
        end
        check("drain_found_req", found, 1);
        check("drain_no_push", n_push, 0);
        check("drain_first_addr", first_addr, 32'h100);
`ifdef UCSBECE154B_PREFETCH_PERF_EN
        check("drain_drop_count", bus.drop_count_o, 2);
`else
        check("drain_drop_count", bus.drop_count_o, 0);
`endif

        // Address wrap at the top of the address space.
        min_delay = 1;
        max_delay = 1;
        step(1, 1, 32'hFFFF_FFFC, 1, 1, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, 1, 1, 0);
            found = s_req_valid;
        end
        check("wrap_found", found, 1);
        check("wrap_top", s_req_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 1, 1, 0);
        check("wrap_valid", s_req_valid, 1);
        check("wrap_zero", s_req_addr, 32'h0);

        // Accept + response + pop together at reserved=3 keeps reserved at 3.
        step(1, 1, 32'h200, 1, 1, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, 1, 1, 0);
            found = s_req_valid;
        end
        check("net_found", found, 1);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 1);
        check("net_req", s_req_valid, 1);
        check("net_push", s_push, 1);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1, 1, 0);
            if (s_req_valid) n_acc++;
        end
        check("net_one_more", n_acc, 1);

        // Reset in the middle of activity.
        do_reset();

        // Randomized traffic.
        min_delay = 1;
        max_delay = 6;
        en_r      = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            if ($urandom_range(0, 19) == 0) en_r = ~en_r;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
            step(en_r, $urandom_range(0, 24) == 0, rpc, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
